// File: rtl/west_feeder.sv
// west_feeder: buffers activation vectors in a FIFO and streams one tile onto in_west, then drains the skewed wavefront.
module west_feeder #(
  parameter int ROW   = 9,
  parameter int COL   = 16,
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [LEN_W-1:0]         i_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ROW*8-1:0]         s_data,
  output logic [ROW*9-1:0]         o_west,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(DEPTH):0]   o_fifo_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(ROW + COL);
  localparam logic [DW-1:0] DRAIN_LEN = DW'(ROW + COL - 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [ROW*8-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LEN_W-1:0] rem;
  logic [DW-1:0] dcnt;
  logic [ROW*9-1:0] lanes;
  logic push, pop;
  assign s_ready = o_fifo_cnt != CW'(DEPTH);
  assign push = s_valid & s_ready;
  assign pop = state == STREAM && o_fifo_cnt != '0;
  for (genvar r = 0; r < ROW; r++) begin : g_lane
    assign lanes[(ROW-r)*9-1 -: 9] = {1'b1, mem[rp][(ROW-r)*8-1 -: 8]};
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wp] <= s_data;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_start) nxt = (i_len != '0) ? STREAM : DONE;
      STREAM:  if (pop && rem == LEN_W'(1)) nxt = DRAIN;
      DRAIN:   if (dcnt == '0) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state == STREAM || state == DRAIN;
    o_done = state == DONE;
  end
  // the drain counter is reloaded on every STREAM cycle so it is full on entry to DRAIN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp <= '0;
      rp <= '0;
      o_fifo_cnt <= '0;
      rem <= '0;
      dcnt <= '0;
      o_west <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      o_fifo_cnt <= o_fifo_cnt + CW'(push) - CW'(pop);
      rem <= (state == IDLE && i_start) ? i_len : rem - LEN_W'(pop);
      dcnt <= (state == STREAM) ? DRAIN_LEN : dcnt - DW'(state == DRAIN && dcnt != '0);
      o_west <= pop ? lanes : '0;
    end
  end
endmodule

// File: tb/tb_west_feeder.sv
// tb_west_feeder: table-driven tile runs plus a reset-mid-stream sequence for west_feeder.
module tb_west_feeder;
  localparam int ROW = 9;
  localparam int COL = 16;
  localparam int DEPTH = 8;
  localparam int LEN_W = 16;
  logic i_clk, i_rst_n, i_start, s_valid, s_ready, o_busy, o_done;
  logic [LEN_W-1:0] i_len;
  logic [ROW*8-1:0] s_data;
  logic [ROW*9-1:0] o_west;
  logic [$clog2(DEPTH):0] o_fifo_cnt;
  typedef struct {
    int pre;
    int base;
    int len;
    int feed;
    int gap;
    int restart;
    int first;
    int done;
    int cnt;
  } tile_t;
  tile_t tbl [6];
  int checks, errors, mcnt;
  int q [$];
  west_feeder #(.ROW(ROW), .COL(COL), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .o_west(o_west),
    .o_busy(o_busy), .o_done(o_done), .o_fifo_cnt(o_fifo_cnt)
  );
  initial i_clk = 0;
  always #5 i_clk = ~i_clk;
  function automatic logic [ROW*8-1:0] mk(input int b);
    logic [ROW*8-1:0] v;
    for (int r = 0; r < ROW; r++) v[(ROW-r)*8-1 -: 8] = 8'(b + r * 17);
    return v;
  endfunction
  function automatic logic [ROW*9-1:0] lanes(input int b);
    logic [ROW*9-1:0] v;
    for (int r = 0; r < ROW; r++) v[(ROW-r)*9-1 -: 9] = {1'b1, 8'(b + r * 17)};
    return v;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input int b);
    s_valid = 1;
    s_data = mk(b);
    chk("push_s_ready", s_ready, mcnt < DEPTH);
    if (mcnt < DEPTH) begin
      q.push_back(b);
      mcnt++;
    end
    @(negedge i_clk);
    s_valid = 0;
    chk("push_fifo_cnt", o_fifo_cnt, mcnt);
  endtask
  task automatic run_tile(input tile_t t);
    logic [ROW*9-1:0] exp_w;
    int rem, fed, nv, first, nd;
    bit rdy;
    for (int k = 0; k < t.pre; k++) push(t.base + k);
    fed = 0; nv = 0; first = -1; nd = 0;
    rem = t.len;
    exp_w = '0;
    i_start = 1;
    i_len = LEN_W'(t.len);
    @(negedge i_clk);
    for (int c = 1; c <= t.done + 2; c++) begin
      i_start = (c == t.restart);
      if (c == t.restart) i_len = '0;
      chk("west", o_west, exp_w);
      chk("done", o_done, c == t.done);
      chk("busy", o_busy, c < t.done);
      rdy = mcnt < DEPTH;
      chk("s_ready", s_ready, rdy);
      if (o_west[ROW*9-1]) begin
        nv++;
        if (first < 0) first = c;
      end
      nd += int'(o_done);
      if (rem > 0 && mcnt > 0) begin
        exp_w = lanes(q.pop_front());
        rem--;
        mcnt--;
      end else exp_w = '0;
      if (t.gap > 0 && fed < t.feed && c % t.gap == 0) begin
        s_valid = 1;
        s_data = mk(t.base + fed);
        if (rdy) begin
          q.push_back(t.base + fed);
          mcnt++;
        end
        fed++;
      end else s_valid = 0;
      @(negedge i_clk);
    end
    s_valid = 0;
    i_start = 0;
    chk("valid_count", nv, t.len);
    chk("first_valid", first, t.first);
    chk("done_count", nd, 1);
    chk("fifo_cnt_after", o_fifo_cnt, t.cnt);
  endtask
  initial begin
    checks = 0; errors = 0; mcnt = 0;
    tbl[0] = '{4, 'h10, 4, 0, 0, -1, 2, 30, 0};
    tbl[1] = '{0, 'h20, 3, 3, 3, -1, 5, 36, 0};
    tbl[2] = '{9, 'h60, 5, 0, 0, -1, 2, 31, 3};
    tbl[3] = '{0, 'h00, 3, 0, 0, -1, 2, 29, 0};
    tbl[4] = '{0, 'h00, 0, 0, 0, -1, -1, 1, 0};
    tbl[5] = '{2, 'h40, 2, 0, 0, 10, 2, 28, 0};
    i_rst_n = 0; i_start = 0; i_len = '0; s_valid = 0; s_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_west", o_west, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_fifo_cnt", o_fifo_cnt, 0);
    i_rst_n = 1;
    @(negedge i_clk);
    for (int k = 0; k < 5; k++) push('h70 + k);
    i_start = 1;
    i_len = 5;
    @(negedge i_clk);
    i_start = 0;
    repeat (2) @(negedge i_clk);
    chk("mid_fifo_cnt", o_fifo_cnt, 3);
    chk("mid_busy", o_busy, 1);
    chk("mid_valid", o_west[ROW*9-1], 1);
    i_rst_n = 0;
    #1;
    chk("arst_west", o_west, 0);
    chk("arst_fifo_cnt", o_fifo_cnt, 0);
    chk("arst_s_ready", s_ready, 1);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    q.delete();
    mcnt = 0;
    @(negedge i_clk);
    for (int t = 0; t < 6; t++) run_tile(tbl[t]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
